// File: rtl/udp_cmd_pkg.sv
// rtl/udp_cmd_pkg.sv - shared state encoding and UDP constants for the command receiver
package udp_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    localparam int          UDP_HDR_BYTES      = 8;
    localparam logic [15:0] DEFAULT_LOCAL_PORT = 16'd8887;

endpackage

// File: rtl/udp_cmd_frame_buf.sv
// rtl/udp_cmd_frame_buf.sv - word RAM with tentative/committed write pointers for per-frame commit or rollback
module udp_cmd_frame_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     commit,
    input  logic                     rollback,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_slots
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_tent;
    logic [AW:0]      wr_commit;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_tent_next;

    assign wr_tent_next = wr_tent + (AW+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_tent   <= '0;
            wr_commit <= '0;
            rd_ptr    <= '0;
        end else begin
            if (rollback)
                wr_tent <= wr_commit;
            else if (wr_en)
                wr_tent <= wr_tent_next;
            // The word written on the commit edge belongs to the committed frame.
            if (commit)
                wr_commit <= wr_en ? wr_tent_next : wr_tent;
            if (rd_en)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_tent[AW-1:0]] <= wr_data;
    end

    assign rd_data    = mem[rd_ptr[AW-1:0]];
    assign empty      = (rd_ptr == wr_commit);
    assign free_slots = (AW+1)'(DEPTH) - (wr_commit - rd_ptr);

endmodule

// File: rtl/udp_cmd_rx.sv
// rtl/udp_cmd_rx.sv - UDP command receiver: filters datagrams, assembles words, commits whole frames (UDP_CMD_RX_STATS_EN adds counters)
module udp_cmd_rx
    import udp_cmd_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT  = DEFAULT_LOCAL_PORT,
    parameter int          WORD_BYTES  = 1,
    parameter int          FRAME_WORDS = 1,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_udp_hdr_valid,
    output logic                      s_udp_hdr_ready,
    input  logic [15:0]               s_udp_dest_port,
    input  logic [15:0]               s_udp_length,
    input  logic [31:0]               s_udp_ip_source_ip,
    input  logic [7:0]                s_udp_payload_axis_tdata,
    input  logic                      s_udp_payload_axis_tvalid,
    output logic                      s_udp_payload_axis_tready,
    input  logic                      s_udp_payload_axis_tlast,
    input  logic                      s_udp_payload_axis_tuser,
    output logic                      m_cmd_valid,
    input  logic                      m_cmd_ready,
    output logic [8*WORD_BYTES-1:0]   m_cmd_data,
    output logic                      m_cmd_last,
    output logic [31:0]               m_cmd_src_ip,
    output logic                      drop_pulse
`ifdef UDP_CMD_RX_STATS_EN
    ,
    output logic [31:0]               cnt_accept,
    output logic [31:0]               cnt_drop
`endif
);

    localparam int TOTAL = WORD_BYTES * FRAME_WORDS;
    localparam int DW    = 8 * WORD_BYTES;
    localparam int EW    = DW + 33;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int BW    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    state_t          state;
    logic [CW-1:0]   byte_cnt;
    logic [BW-1:0]   bw_cnt;
    logic [DW-1:0]   asm_reg;
    logic [31:0]     src_ip;

    logic            beat, pay_beat, hdr_fire, hdr_ok;
    logic [CW-1:0]   byte_cnt_next;
    logic            full_cnt, word_done;
    logic [DW+7:0]   asm_wide;
    logic [DW-1:0]   asm_next;
    logic            wr_en, commit, rollback, rd_en, empty;
    logic [EW-1:0]   rd_data;
    logic [AW:0]     free_slots;

    assign s_udp_hdr_ready           = (state == ST_IDLE);
    assign s_udp_payload_axis_tready = (state == ST_PAYLOAD) || (state == ST_DROP);

    assign beat     = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready;
    assign pay_beat = beat && (state == ST_PAYLOAD);
    assign hdr_fire = s_udp_hdr_valid && s_udp_hdr_ready;
    assign hdr_ok   = (s_udp_dest_port == LOCAL_PORT)
                   && (s_udp_length == 16'(UDP_HDR_BYTES + TOTAL))
                   && (free_slots >= (AW+1)'(FRAME_WORDS));

    assign byte_cnt_next = byte_cnt + CW'(1);
    assign full_cnt      = (byte_cnt_next == CW'(TOTAL));
    assign word_done     = (bw_cnt == BW'(WORD_BYTES - 1));
    assign asm_wide      = {asm_reg, s_udp_payload_axis_tdata};
    assign asm_next      = asm_wide[DW-1:0];

    assign wr_en    = pay_beat && word_done;
    assign commit   = pay_beat && s_udp_payload_axis_tlast && full_cnt && !s_udp_payload_axis_tuser;
    assign rollback = pay_beat && (s_udp_payload_axis_tlast ? (s_udp_payload_axis_tuser || !full_cnt)
                                                            : full_cnt);
    assign drop_pulse = !rst && ((hdr_fire && !hdr_ok) || rollback);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            bw_cnt   <= '0;
            asm_reg  <= '0;
            src_ip   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (hdr_fire) begin
                    src_ip   <= s_udp_ip_source_ip;
                    byte_cnt <= '0;
                    bw_cnt   <= '0;
                    state    <= hdr_ok ? ST_PAYLOAD : ST_DROP;
                end
                ST_PAYLOAD: if (beat) begin
                    asm_reg  <= asm_next;
                    byte_cnt <= byte_cnt_next;
                    bw_cnt   <= word_done ? '0 : bw_cnt + BW'(1);
                    if (s_udp_payload_axis_tlast)
                        state <= ST_IDLE;
                    else if (rollback)
                        state <= ST_DROP;
                end
                ST_DROP: if (beat && s_udp_payload_axis_tlast)
                    state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    udp_cmd_frame_buf #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    ({full_cnt, src_ip, asm_next}),
        .commit     (commit),
        .rollback   (rollback),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .free_slots (free_slots)
    );

    // One-word skid: refills on the same edge the current word is taken.
    assign rd_en = !rst && !empty && (!m_cmd_valid || m_cmd_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            m_cmd_valid  <= 1'b0;
            m_cmd_data   <= '0;
            m_cmd_last   <= 1'b0;
            m_cmd_src_ip <= '0;
        end else if (rd_en) begin
            m_cmd_valid                              <= 1'b1;
            {m_cmd_last, m_cmd_src_ip, m_cmd_data}   <= rd_data;
        end else if (m_cmd_ready) begin
            m_cmd_valid <= 1'b0;
        end
    end

`ifdef UDP_CMD_RX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_accept <= '0;
            cnt_drop   <= '0;
        end else begin
            if (commit && cnt_accept != '1)
                cnt_accept <= cnt_accept + 32'd1;
            if (drop_pulse && cnt_drop != '1)
                cnt_drop <= cnt_drop + 32'd1;
        end
    end
`endif

endmodule

// File: doc/udp_cmd_rx.md
UDP_CMD_RX -- requirements
Module: udp_cmd_rx

Interface
REQ-001 SHALL have parameters: LOCAL_PORT, default 16'd8887, UDP destination port accepted; WORD_BYTES, default 1, payload bytes per output word; FRAME_WORDS, default 1, output words per accepted datagram; FIFO_DEPTH, default 16, word slots in the frame buffer (power of two, >= FRAME_WORDS).
REQ-002 SHALL have these ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock
- rst  in  1  synchronous active-high reset
- s_udp_hdr_valid  in  1  UDP header valid
- s_udp_hdr_ready  out  1  header accept
- s_udp_dest_port  in  16  destination port
- s_udp_length  in  16  UDP length field (header + payload)
- s_udp_ip_source_ip  in  32  sender IP
- s_udp_payload_axis_tdata  in  8  payload byte
- s_udp_payload_axis_tvalid  in  1  byte valid
- s_udp_payload_axis_tready  out  1  byte accept
- s_udp_payload_axis_tlast  in  1  last payload byte
- s_udp_payload_axis_tuser  in  1  frame error (sampled with tlast)
- m_cmd_valid  out  1  output word valid
- m_cmd_ready  in  1  output word accept
- m_cmd_data  out  8*WORD_BYTES  assembled word, first byte in MSBs
- m_cmd_last  out  1  final word of datagram
- m_cmd_src_ip  out  32  sender IP of this datagram
- drop_pulse  out  1  one-cycle strobe per discarded datagram

Function
REQ-003 SHALL implement states IDLE, PAYLOAD and DROP; s_udp_hdr_ready=1 only in IDLE.
REQ-004 On header handshake in IDLE, SHALL go to PAYLOAD only if dest_port==LOCAL_PORT, length==8+WORD_BYTES*FRAME_WORDS, and free (uncommitted) slots >= FRAME_WORDS; otherwise go to DROP.
REQ-005 s_udp_payload_axis_tready SHALL be 1 in PAYLOAD and DROP and 0 in IDLE.
REQ-006 In PAYLOAD, SHALL shift bytes into an assembly register; after every WORD_BYTES bytes, SHALL write the word to the buffer at the tentative write pointer; the committed pointer SHALL NOT move.
REQ-007 On a tlast beat in PAYLOAD with byte count == WORD_BYTES*FRAME_WORDS and tuser==0, SHALL set committed pointer = tentative pointer on that edge and return to IDLE.
REQ-008 In PAYLOAD, SHALL roll the tentative pointer back to the committed pointer, pulse drop_pulse, and go to IDLE on any of these: tlast with tuser==1; tlast before the full byte count; or the full count reached without tlast (in the last case, go to DROP instead of IDLE).
REQ-009 DROP SHALL discard beats until a tlast beat, then go to IDLE; drop_pulse SHALL fire once per header-rejected datagram, on the header handshake cycle.
REQ-010 The output stage SHALL be a registered skid of one word; it loads the next committed word on the edge after that word is committed, so m_cmd_valid is first high one cycle after the commit edge.
REQ-011 m_cmd_data, m_cmd_last and m_cmd_src_ip SHALL stay stable while m_cmd_valid && !m_cmd_ready.
REQ-012 The output SHALL sustain one word per cycle when m_cmd_ready is held at 1.
REQ-013 Simultaneous commit and read SHALL both take effect; pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit used for full/empty.
REQ-014 The stored source IP SHALL be latched per datagram at the header handshake and written alongside each word.

Reset
REQ-015 On rst, all outputs SHALL be 0 except s_udp_hdr_ready=1; state SHALL be IDLE; all pointers SHALL be 0; any partial or committed data SHALL be discarded, even if rst arrives mid-frame.

Configuration
REQ-016 When UDP_CMD_RX_STATS_EN is defined, SHALL add these outputs:
- cnt_accept  out  32  datagrams committed
- cnt_drop  out  32  drop_pulse count
Both SHALL reset to 0 and saturate at all-ones. Without the macro, the ports and logic SHALL be absent.

Structure
REQ-017 A shared package udp_cmd_pkg SHALL hold the state enum, UDP_HDR_BYTES=8, and the default LOCAL_PORT.
REQ-018 The buffer SHALL be a sub-module udp_cmd_frame_buf (dual-pointer RAM with commit/rollback); the FSM and assembly logic stay in udp_cmd_rx.

Verification
REQ-019 Defaults; port 8887, length 9, byte 0xA5, tuser 0 -> one word 0xA5 with last=1 and src_ip echoed; m_cmd_valid one cycle after the commit edge.
REQ-020 Port 8888 or length 10 -> drop_pulse=1 once, no output, all 2 bytes consumed.
REQ-021 WORD_BYTES=2, FRAME_WORDS=2; bytes 11 22 33 44 with tuser=1 on tlast -> no output, pointers restored, next good frame delivers 0x1122 then 0x3344 (last=1).
REQ-022 FIFO_DEPTH=4, FRAME_WORDS=2, m_cmd_ready=0; send 3 good frames -> frames 1 and 2 stored, frame 3 dropped; release ready -> exactly 4 words in order.
REQ-023 rst asserted mid-PAYLOAD -> all outputs at reset values next cycle; the next good frame is delivered normally.
REQ-024 With UDP_CMD_RX_STATS_EN defined; 5 good and 3 bad datagrams -> cnt_accept=5, cnt_drop=3.
